spi_xfer_ctrl: RTL and testbench

Master-side transfer sequencer for the SPI byte shift register. It accepts a byte-transfer request and generates the baud-rate SCLK. It drives the shift register's control strobes: `send_data`, `receive_data`, `flag_low`/`flag_high` and `flags_low`/`flags_high`. It also owns slave select and signals completion. It sits between the APB register file and the shift register.

---
 rtl/spi_xfer_ctrl_if.sv | 37 +++
 rtl/spi_xfer_ctrl.sv | 132 +++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_xfer_ctrl_if.sv
// spi_xfer_ctrl_if
//   Bundles the request side (enable, mode, baud settings, tx handshake) and
//   the shift-register control side (SCLK, slave select, strobes, status) of
//   the SPI transfer sequencer.
//   master : the sequencer itself (drives sclk/ss/strobes/status, tx_ready)
//   slave  : the register file / shift register side (drives spe, cpol,
//            sppr, spr, tx_valid)
interface spi_xfer_ctrl_if;
  logic       spe;
  logic       cpol;
  logic [2:0] sppr;
  logic [2:0] spr;
  logic       tx_valid;
  logic       tx_ready;
  logic       sclk;
  logic       ss;
  logic       send_data;
  logic       receive_data;
  logic       flag_low;
  logic       flag_high;
  logic       flags_low;
  logic       flags_high;
  logic       busy;
  logic       done;

  modport master (
    input  spe, cpol, sppr, spr, tx_valid,
    output tx_ready, sclk, ss, send_data, receive_data,
           flag_low, flag_high, flags_low, flags_high, busy, done
  );

  modport slave (
    output spe, cpol, sppr, spr, tx_valid,
    input  tx_ready, sclk, ss, send_data, receive_data,
           flag_low, flag_high, flags_low, flags_high, busy, done
  );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl
//   Master-side byte transfer sequencer. Accepts a byte request, generates the
//   baud-rate SCLK (16 edges per byte), drives slave select and the shift
//   register strobes, and pulses done when the byte completes.
// Ports
//   PCLK     : system clock
//   PRESETn  : asynchronous active-low reset
//   bus      : spi_xfer_ctrl_if.master
//              in : spe, cpol, sppr, spr, tx_valid
//              out: tx_ready, sclk, ss, send_data, receive_data, flag_low,
//                   flag_high, flags_low, flags_high, busy, done
// Parameters
//   DIV_W    : half-period counter width, must hold 1024
module spi_xfer_ctrl #(
  parameter int DIV_W = 11
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  spi_xfer_ctrl_if.master  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, XFER, DONE} state_t;

  state_t           state, state_nxt;
  // Half-period H = D/2 = (sppr+1) << spr is held instead of D itself;
  // reset value 1 corresponds to D = 2.
  logic [DIV_W-1:0] half_q;
  logic [DIV_W-1:0] half_nxt;
  logic [DIV_W-1:0] hcnt, hcnt_nxt;
  logic [3:0]       ecnt, ecnt_nxt;
  logic             sclk_q, sclk_nxt;
  logic             cpol_q;
  logic             accept;
  logic             hit;
  logic             pre_hit;

  assign half_nxt = DIV_W'({1'b0, bus.sppr} + 4'd1) << bus.spr;

  assign bus.tx_ready = bus.spe & ((state == IDLE) | (state == DONE));
  assign accept       = bus.tx_valid & bus.tx_ready;

  // hit: last cycle of a half period, SCLK toggles at the end of it.
  // pre_hit: one cycle earlier; with H = 1 there is no earlier cycle, so it
  // coincides with hit.
  assign hit     = (state == XFER) && (hcnt == half_q - DIV_W'(1));
  assign pre_hit = (half_q == DIV_W'(1)) ? hit
                 : ((state == XFER) && (hcnt == half_q - DIV_W'(2)));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state  <= IDLE;
      hcnt   <= '0;
      ecnt   <= '0;
      sclk_q <= 1'b0;
      cpol_q <= 1'b0;
      half_q <= DIV_W'(1);
    end else begin
      state  <= state_nxt;
      hcnt   <= hcnt_nxt;
      ecnt   <= ecnt_nxt;
      sclk_q <= sclk_nxt;
      if (accept) begin
        cpol_q <= bus.cpol;
        half_q <= half_nxt;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    hcnt_nxt  = hcnt;
    ecnt_nxt  = ecnt;
    sclk_nxt  = sclk_q;
    if (!bus.spe) begin
      // Abort: back to idle with counters cleared, no done.
      state_nxt = IDLE;
      hcnt_nxt  = '0;
      ecnt_nxt  = '0;
      sclk_nxt  = cpol_q;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state_nxt = LOAD;
            sclk_nxt  = bus.cpol;
          end
        end
        LOAD: begin
          hcnt_nxt  = '0;
          ecnt_nxt  = '0;
          state_nxt = XFER;
        end
        XFER: begin
          if (hit) begin
            hcnt_nxt = '0;
            ecnt_nxt = ecnt + 4'd1;
            sclk_nxt = ~sclk_q;
            // 16th toggle leaves SCLK back at its idle level.
            if (ecnt == 4'd15) state_nxt = DONE;
          end else begin
            hcnt_nxt = hcnt + DIV_W'(1);
          end
        end
        DONE: begin
          hcnt_nxt = '0;
          ecnt_nxt = '0;
          if (accept) begin
            state_nxt = LOAD;
            sclk_nxt  = bus.cpol;
          end else begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // In IDLE SCLK follows the live cpol so the idle level is right before the
  // first transfer; otherwise it comes from the register.
  assign bus.sclk         = (state == IDLE) ? bus.cpol : sclk_q;
  assign bus.ss           = (state == IDLE);
  assign bus.send_data    = (state == LOAD);
  assign bus.receive_data = (state == LOAD) | (state == XFER);
  assign bus.busy         = (state == LOAD) | (state == XFER);
  assign bus.done         = (state == DONE);
  assign bus.flag_low     = hit & ~sclk_q;
  assign bus.flag_high    = hit & sclk_q;
  assign bus.flags_low    = pre_hit & ~sclk_q;
  assign bus.flags_high   = pre_hit & sclk_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed testbench for spi_xfer_ctrl.
module tb_spi_xfer_ctrl;
  logic PCLK = 1'b0;
  logic PRESETn;

  always #5 PCLK = ~PCLK;

  spi_xfer_ctrl_if bus();

  spi_xfer_ctrl #(.DIV_W(11)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int done_c;
    int ndone;
    int nfl;
    int nfh;
    int nfsl;
    int nfsh;
    int nsend;
    int send_c1;
    int nbusy;
    int sclk_err;
    int ss_err;
    int lead_err;
    int first_hi;
    int sclk_end;
    int ss_after;
  } res_t;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] strobes();
    return {bus.send_data, bus.receive_data, bus.flag_low, bus.flag_high,
            bus.flags_low, bus.flags_high, bus.busy, bus.done};
  endfunction

  // Called in the accept cycle T with tx_valid already high; observes
  // cycles T+1 .. T+16h+4.
  task automatic run_xfer(input int h, input logic cp, output res_t r);
    logic pfl, pfh;
    bit   seen;
    r = '{default: 0};
    r.done_c = -1;
    pfl = 1'b0;
    pfh = 1'b0;
    seen = 1'b0;
    for (int c = 1; c <= 16 * h + 4; c++) begin
      tick();
      if (c == 1) begin
        bus.tx_valid = 1'b0;
        r.send_c1 = bus.send_data ? 1 : 0;
      end
      if (bus.send_data)  r.nsend++;
      if (bus.busy)       r.nbusy++;
      if (bus.flag_low)   r.nfl++;
      if (bus.flag_high)  r.nfh++;
      if (bus.flags_low)  r.nfsl++;
      if (bus.flags_high) r.nfsh++;
      if (!seen && (bus.flag_low || bus.flag_high)) begin
        seen = 1'b1;
        r.first_hi = bus.flag_high ? 1 : 0;
      end
      if (c >= 2 && c <= 16 * h + 1) begin
        if (bus.sclk !== (cp ^ ((((c - 2) / h) % 2) == 1))) r.sclk_err++;
        if (bus.ss !== 1'b0) r.ss_err++;
      end
      if (h >= 2) begin
        if (bus.flag_low !== pfl || bus.flag_high !== pfh) r.lead_err++;
      end else if (bus.flag_low !== bus.flags_low || bus.flag_high !== bus.flags_high) begin
        r.lead_err++;
      end
      pfl = bus.flags_low;
      pfh = bus.flags_high;
      if (bus.done) begin
        r.ndone++;
        if (r.done_c < 0) begin
          r.done_c   = c;
          r.sclk_end = bus.sclk ? 1 : 0;
        end
      end
      if (c == 16 * h + 3) r.ss_after = bus.ss ? 1 : 0;
    end
  endtask

  task automatic check_res(input string p, input res_t r, input int h, input logic cp);
    chkn({p, ".done_cycle"}, r.done_c, 2 + 16 * h);
    chkn({p, ".done_count"}, r.ndone, 1);
    chkn({p, ".flag_low"},   r.nfl, 8);
    chkn({p, ".flag_high"},  r.nfh, 8);
    chkn({p, ".flags_low"},  r.nfsl, 8);
    chkn({p, ".flags_high"}, r.nfsh, 8);
    chkn({p, ".send_at_T1"}, r.send_c1, 1);
    chkn({p, ".send_count"}, r.nsend, 1);
    chkn({p, ".busy_cycles"}, r.nbusy, 1 + 16 * h);
    chkn({p, ".sclk_shape"}, r.sclk_err, 0);
    chkn({p, ".ss_low"},     r.ss_err, 0);
    chkn({p, ".flags_lead"}, r.lead_err, 0);
    chkn({p, ".first_pulse"}, r.first_hi, cp ? 1 : 0);
    chkn({p, ".sclk_end"},   r.sclk_end, cp ? 1 : 0);
    chkn({p, ".ss_release"}, r.ss_after, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    res_t r;
    int   bb_ss_err, d1, d2, s1, s2, nflags, edges, ndone;

    // Reset values
    PRESETn      = 1'b0;
    bus.spe      = 1'b0;
    bus.cpol     = 1'b0;
    bus.sppr     = 3'd0;
    bus.spr      = 3'd0;
    bus.tx_valid = 1'b0;
    #12;
    chk1("rst.sclk", bus.sclk, 1'b0);
    chk1("rst.ss", bus.ss, 1'b1);
    chk1("rst.tx_ready", bus.tx_ready, 1'b0);
    chkn("rst.strobes", int'(strobes()), 0);
    tick();
    PRESETn  = 1'b1;
    bus.spe  = 1'b1;
    bus.cpol = 1'b1;
    #1;
    chk1("idle.sclk_cpol1", bus.sclk, 1'b1);
    chk1("idle.ss", bus.ss, 1'b1);
    chk1("idle.tx_ready", bus.tx_ready, 1'b1);
    chkn("idle.strobes", int'(strobes()), 0);

    // Fastest rate: D=2, H=1, cpol=0
    bus.cpol = 1'b0;
    bus.sppr = 3'd0;
    bus.spr  = 3'd0;
    bus.tx_valid = 1'b1;
    run_xfer(1, 1'b0, r);
    check_res("fast", r, 1, 1'b0);

    // Divided rate: D=8, H=4, cpol=1
    bus.cpol = 1'b1;
    bus.sppr = 3'd1;
    bus.spr  = 3'd1;
    bus.tx_valid = 1'b1;
    run_xfer(4, 1'b1, r);
    check_res("div8", r, 4, 1'b1);

    // Back-to-back at D=2: second accept in the DONE cycle T+18
    bus.cpol = 1'b0;
    bus.sppr = 3'd0;
    bus.spr  = 3'd0;
    bus.tx_valid = 1'b1;
    bb_ss_err = 0; d1 = -1; d2 = -1; s1 = -1; s2 = -1; nflags = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 19) bus.tx_valid = 1'b0;
      if (c <= 36 && bus.ss !== 1'b0) bb_ss_err++;
      if (bus.done)      begin if (d1 < 0) d1 = c; else if (d2 < 0) d2 = c; end
      if (bus.send_data) begin if (s1 < 0) s1 = c; else if (s2 < 0) s2 = c; end
      if (bus.flag_low)  nflags++;
      if (bus.flag_high) nflags++;
      if (c == 37) chk1("b2b.ss_release", bus.ss, 1'b1);
    end
    chkn("b2b.ss_low", bb_ss_err, 0);
    chkn("b2b.done1", d1, 18);
    chkn("b2b.done2", d2, 36);
    chkn("b2b.send1", s1, 1);
    chkn("b2b.send2", s2, 19);
    chkn("b2b.edges", nflags, 32);

    // Abort: spe dropped during the cycle of the 5th SCLK edge (D=8)
    bus.cpol = 1'b0;
    bus.sppr = 3'd1;
    bus.spr  = 3'd1;
    bus.tx_valid = 1'b1;
    edges = 0;
    for (int c = 1; c <= 21; c++) begin
      tick();
      if (c == 1) bus.tx_valid = 1'b0;
      if (bus.flag_low || bus.flag_high) edges++;
    end
    chkn("abort.edges_before", edges, 5);
    bus.spe = 1'b0;
    tick();
    chk1("abort.ss", bus.ss, 1'b1);
    chk1("abort.sclk", bus.sclk, 1'b0);
    chkn("abort.strobes", int'(strobes()), 0);
    chk1("abort.tx_ready", bus.tx_ready, 1'b0);
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.done) ndone++;
    end
    chkn("abort.no_done", ndone, 0);
    bus.spe  = 1'b1;
    bus.cpol = 1'b1;
    #1;
    chk1("abort.idle_sclk", bus.sclk, 1'b1);
    bus.tx_valid = 1'b1;
    run_xfer(4, 1'b1, r);
    check_res("abort.resume", r, 4, 1'b1);

    // Asynchronous reset in the middle of XFER
    bus.cpol = 1'b0;
    bus.sppr = 3'd1;
    bus.spr  = 3'd1;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    repeat (9) tick();
    chk1("arst.busy_before", bus.busy, 1'b1);
    #2;
    PRESETn = 1'b0;
    #1;
    chk1("arst.ss", bus.ss, 1'b1);
    chk1("arst.sclk", bus.sclk, 1'b0);
    chkn("arst.strobes", int'(strobes()), 0);
    chk1("arst.tx_ready", bus.tx_ready, 1'b1);
    tick();
    PRESETn  = 1'b1;
    bus.sppr = 3'd0;
    bus.spr  = 3'd0;
    bus.tx_valid = 1'b1;
    run_xfer(1, 1'b0, r);
    check_res("arst.resume", r, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
